// File: rtl/cnn_pkg.sv
// Shared CNN types and constants: data format, layer-memory selects,
// fully-connected stage states and Q4.16 saturation limits.
package cnn_pkg;

  localparam int DW   = 20;
  localparam int FRAC = 16;

  localparam logic [2:0] CSEL_NONE = 3'b000;
  localparam logic [2:0] CSEL_L0   = 3'b001;
  localparam logic [2:0] CSEL_L1   = 3'b011;
  localparam logic [2:0] CSEL_L2   = 3'b101;

  localparam logic [DW-1:0] Q_MAX = 20'h7FFFF;
  localparam logic [DW-1:0] Q_MIN = 20'h80000;

  typedef enum logic [2:0] {
    FC_IDLE,
    FC_FETCH,
    FC_LAST,
    FC_ROUND,
    FC_WRITE,
    FC_DONE
  } fc_state_t;

endpackage

// File: rtl/fc_neuron_if.sv
// Layer-memory and weight-ROM port bundle of the dense stage.
// master = neuron side, slave = memory side.
interface fc_neuron_if #(
  parameter int DW = 20
);

  logic                 crd;
  logic [11:0]          caddr_rd;
  logic signed [DW-1:0] cdata_rd;
  logic [9:0]           waddr;
  logic signed [DW-1:0] wdata;
  logic [2:0]           csel;
  logic                 cwr;
  logic [11:0]          caddr_wr;
  logic [DW-1:0]        cdata_wr;

  modport master (
    output crd, caddr_rd, waddr,
    output csel, cwr, caddr_wr, cdata_wr,
    input  cdata_rd, wdata
  );

  modport slave (
    input  crd, caddr_rd, waddr,
    input  csel, cwr, caddr_wr, cdata_wr,
    output cdata_rd, wdata
  );

endinterface

// File: rtl/fc_round_sat.sv
// Wide accumulator -> Q4.16: round half up, then saturate.
// FC_RELU_EN defined: negative results are clamped to zero.
module fc_round_sat #(
  parameter int AW   = 50,
  parameter int DW   = cnn_pkg::DW,
  parameter int FRAC = cnn_pkg::FRAC
) (
  input  logic signed [AW-1:0] acc_i,
  output logic [DW-1:0]        res_o
);
  import cnn_pkg::*;

  localparam int TW = AW - FRAC + 1;

  logic signed [TW-1:0] rnd;
  logic signed [TW-1:0] hi;
  logic signed [TW-1:0] lo;
  logic [DW-1:0]        sat;
  logic                 unused_lsb;

  assign hi = TW'($signed(Q_MAX));
  assign lo = TW'($signed(Q_MIN));
  assign unused_lsb = ^acc_i[FRAC-2:0];

  // One extra bit so the +1 of rounding can never wrap
  always_comb begin
    rnd = {acc_i[AW-1], acc_i[AW-1:FRAC]}
        + TW'(acc_i[FRAC-1]);
    if (rnd > hi) begin
      sat = Q_MAX;
    end else if (rnd < lo) begin
      sat = Q_MIN;
    end else begin
      sat = rnd[DW-1:0];
    end
`ifdef FC_RELU_EN
    res_o = sat[DW-1] ? '0 : sat;
`else
    res_o = sat;
`endif
  end

endmodule

// File: rtl/fc_neuron.sv
// Single dense neuron: streams N_IN features x weights through a MAC,
// rounds/saturates and writes one word. ReLU option: FC_RELU_EN.
module fc_neuron #(
  parameter int          N_IN     = 1024,
  parameter int          DW       = 20,
  parameter int          FRAC     = 16,
  parameter logic [11:0] DST_ADDR = 12'd0
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     start,
  output logic     busy,
  output logic     done,
  fc_neuron_if.master mem
);
  import cnn_pkg::*;

  localparam int IW = $clog2(N_IN);
  localparam int PW = 2 * DW;
  localparam int AW = PW + IW;

  fc_state_t            state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d, idx_nxt;
  logic signed [AW-1:0] acc_q, acc_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 crd_q, crd_d;
  logic [2:0]           csel_q, csel_d;
  logic                 cwr_q, cwr_d;
  logic [11:0]          caddr_rd_q, caddr_rd_d;
  logic [9:0]           waddr_q, waddr_d;
  logic [11:0]          caddr_wr_q, caddr_wr_d;
  logic [DW-1:0]        cdata_wr_q, cdata_wr_d;

  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] prod_x;
  logic                 mac_en;
  logic [DW-1:0]        res;

  assign prod   = mem.cdata_rd * mem.wdata;
  assign prod_x = {{IW{prod[PW-1]}}, prod};

  // Read data lags the address by one cycle, so FETCH
  // cycle 0 has nothing to add and LAST adds the tail.
  assign mac_en = (state_q == FC_FETCH && idx_q != '0)
               || (state_q == FC_LAST);

  fc_round_sat #(
    .AW   (AW),
    .DW   (DW),
    .FRAC (FRAC)
  ) u_round_sat (
    .acc_i (acc_q),
    .res_o (res)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    busy_d     = busy_q;
    done_d     = done_q;
    crd_d      = crd_q;
    csel_d     = csel_q;
    cwr_d      = cwr_q;
    caddr_rd_d = caddr_rd_q;
    waddr_d    = waddr_q;
    caddr_wr_d = caddr_wr_q;
    cdata_wr_d = cdata_wr_q;
    idx_nxt    = idx_q + 1'b1;

    if (mac_en) begin
      acc_d = acc_q + prod_x;
    end

    unique case (state_q)
      FC_IDLE: begin
        if (start) begin
          state_d    = FC_FETCH;
          idx_d      = '0;
          acc_d      = '0;
          busy_d     = 1'b1;
          crd_d      = 1'b1;
          csel_d     = CSEL_L1;
          caddr_rd_d = '0;
          waddr_d    = '0;
        end
      end
      FC_FETCH: begin
        if (&idx_q) begin
          state_d    = FC_LAST;
          crd_d      = 1'b0;
          csel_d     = CSEL_NONE;
          caddr_rd_d = '0;
          waddr_d    = '0;
        end else begin
          idx_d      = idx_nxt;
          caddr_rd_d = 12'(idx_nxt);
          waddr_d    = 10'(idx_nxt);
        end
      end
      FC_LAST: begin
        state_d = FC_ROUND;
      end
      FC_ROUND: begin
        state_d    = FC_WRITE;
        cwr_d      = 1'b1;
        csel_d     = CSEL_L2;
        caddr_wr_d = DST_ADDR;
        cdata_wr_d = res;
      end
      FC_WRITE: begin
        state_d    = FC_DONE;
        cwr_d      = 1'b0;
        csel_d     = CSEL_NONE;
        caddr_wr_d = '0;
        busy_d     = 1'b0;
        done_d     = 1'b1;
      end
      FC_DONE: begin
        state_d = FC_IDLE;
        done_d  = 1'b0;
      end
      default: begin
        state_d = FC_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FC_IDLE;
      idx_q      <= '0;
      acc_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      crd_q      <= 1'b0;
      csel_q     <= CSEL_NONE;
      cwr_q      <= 1'b0;
      caddr_rd_q <= '0;
      waddr_q    <= '0;
      caddr_wr_q <= '0;
      cdata_wr_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      crd_q      <= crd_d;
      csel_q     <= csel_d;
      cwr_q      <= cwr_d;
      caddr_rd_q <= caddr_rd_d;
      waddr_q    <= waddr_d;
      caddr_wr_q <= caddr_wr_d;
      cdata_wr_q <= cdata_wr_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign mem.crd      = crd_q;
  assign mem.csel     = csel_q;
  assign mem.cwr      = cwr_q;
  assign mem.caddr_rd = caddr_rd_q;
  assign mem.waddr    = waddr_q;
  assign mem.caddr_wr = caddr_wr_q;
  assign mem.cdata_wr = cdata_wr_q;

endmodule

// File: tb/tb_fc_neuron.sv
// Bench for fc_neuron: directed table, reset/re-start sequences,
// and random feature/weight sets against a plain-arithmetic model.
module tb_fc_neuron;

  localparam int N = 1024;

  logic clk;
  logic reset;
  logic start;
  logic busy;
  logic done;

  fc_neuron_if #(.DW(20)) m ();

  fc_neuron #(.N_IN(N)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .busy  (busy),
    .done  (done),
    .mem   (m.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [19:0] feat [N];
  logic [19:0] wt   [N];

  always @(posedge clk) begin
    if (m.crd) m.cdata_rd <= feat[m.caddr_rd[9:0]];
    m.wdata <= wt[m.waddr];
  end

  int nvec = 0;
  int nerr = 0;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  function automatic logic [19:0] model();
    longint s;
    longint r;
    s = 0;
    for (int i = 0; i < N; i++)
      s += longint'($signed(feat[i])) * longint'($signed(wt[i]));
    r = (s + 64'sd32768) >>> 16;
    if (r > 524287) r = 524287;
    else if (r < -524288) r = -524288;
`ifdef FC_RELU_EN
    if (r < 0) r = 0;
`endif
    return r[19:0];
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < N; i++) begin
      feat[i] = '0;
      wt[i]   = '0;
    end
  endtask

  task automatic run_eval(input string nm, input logic [19:0] exp,
                          input int pulse_at);
    int ncwr, ndone, cwr_k, done_k;
    logic [19:0] wd;
    logic [11:0] wa;
    logic [2:0]  ws;
    logic b1, bd;
    ncwr = 0; ndone = 0; cwr_k = -1; done_k = -1;
    wd = '0; wa = '1; ws = '0; b1 = 1'b0; bd = 1'b1;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= N + 8; k++) begin
      @(negedge clk);
      if (k == 1) b1 = busy;
      if (m.cwr) begin
        ncwr++; cwr_k = k;
        wd = m.cdata_wr; wa = m.caddr_wr; ws = m.csel;
      end
      if (done) begin
        ndone++; done_k = k; bd = busy;
      end
      start = (k == pulse_at + 1);
    end
    start = 1'b0;
    chk({nm, " data"}, 32'(wd), 32'(exp));
    chk({nm, " cwr_count"}, ncwr, 1);
    chk({nm, " done_count"}, ndone, 1);
    chk({nm, " cwr_cycle"}, cwr_k, N + 3);
    chk({nm, " done_cycle"}, done_k, N + 4);
    chk({nm, " wr_addr_sel"}, {17'd0, ws, wa}, {17'd0, 3'b101, 12'd0});
    chk({nm, " busy_e1"}, 32'(b1), 1);
    chk({nm, " busy_at_done"}, 32'(bd), 0);
  endtask

  typedef struct {
    string       nm;
    bit          all;
    int          i1;
    logic [19:0] f1;
    logic [19:0] w1;
    int          i2;
    logic [19:0] f2;
    logic [19:0] w2;
    logic [19:0] exp;
    int          pulse;
  } vec_t;

`ifdef FC_RELU_EN
  localparam logic [19:0] E_NEG1 = 20'h00000;
  localparam logic [19:0] E_NSAT = 20'h00000;
  localparam logic [19:0] E_NMIN = 20'h00000;
`else
  localparam logic [19:0] E_NEG1 = 20'hF0000;
  localparam logic [19:0] E_NSAT = 20'h80000;
  localparam logic [19:0] E_NMIN = 20'h80000;
`endif

  task automatic load(input vec_t v);
    clear_mem();
    if (v.all) begin
      for (int i = 0; i < N; i++) begin
        feat[i] = v.f1;
        wt[i]   = v.w1;
      end
    end else begin
      feat[v.i1] = v.f1;
      wt[v.i1]   = v.w1;
      if (v.i2 >= 0) begin
        feat[v.i2] = v.f2;
        wt[v.i2]   = v.w2;
      end
    end
  endtask

  initial begin
    vec_t tbl[$];
    tbl.push_back('{"all_one", 1'b1, 0, 20'h10000, 20'h10000,
                    -1, 20'h0, 20'h0, 20'h7FFFF, -1});
    tbl.push_back('{"last_feat", 1'b0, 1023, 20'h10000, 20'h08000,
                    -1, 20'h0, 20'h0, 20'h08000, -1});
    tbl.push_back('{"half_up", 1'b0, 0, 20'h00001, 20'h08000,
                    -1, 20'h0, 20'h0, 20'h00001, -1});
    tbl.push_back('{"below_half", 1'b0, 0, 20'h00001, 20'h07FFF,
                    -1, 20'h0, 20'h0, 20'h00000, -1});
    tbl.push_back('{"neg_one", 1'b0, 0, 20'h10000, 20'hF0000,
                    -1, 20'h0, 20'h0, E_NEG1, -1});
    tbl.push_back('{"round_ovf", 1'b0, 0, 20'h7FFFF, 20'h10000,
                    1, 20'h00001, 20'h08000, 20'h7FFFF, -1});
    tbl.push_back('{"neg_half", 1'b0, 5, 20'hFFFFF, 20'h08000,
                    -1, 20'h0, 20'h0, 20'h00000, -1});
    tbl.push_back('{"neg_sat", 1'b1, 0, 20'h80000, 20'h7FFFF,
                    -1, 20'h0, 20'h0, E_NSAT, -1});
    tbl.push_back('{"exact_min", 1'b0, 512, 20'h80000, 20'h10000,
                    -1, 20'h0, 20'h0, E_NMIN, -1});
    tbl.push_back('{"restart_ign", 1'b0, 1023, 20'h10000, 20'h08000,
                    -1, 20'h0, 20'h0, 20'h08000, 10});

    clear_mem();
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst busy_done", {30'd0, busy, done}, 0);
    chk("rst strobes", {30'd0, m.crd, m.cwr}, 0);
    chk("rst csel", 32'(m.csel), 0);
    chk("rst caddr_rd", 32'(m.caddr_rd), 0);
    chk("rst waddr", 32'(m.waddr), 0);
    chk("rst caddr_wr", 32'(m.caddr_wr), 0);
    chk("rst cdata_wr", 32'(m.cdata_wr), 0);
    reset = 1'b0;
    @(negedge clk);

    foreach (tbl[t]) begin
      load(tbl[t]);
      run_eval(tbl[t].nm, tbl[t].exp, tbl[t].pulse);
    end

    // Reset in the middle of FETCH, then a clean evaluation
    begin
      int ncwr, ndone;
      ncwr = 0; ndone = 0;
      load(tbl[1]);
      @(negedge clk);
      start = 1'b1;
      for (int k = 1; k <= 501; k++) begin
        @(negedge clk);
        start = 1'b0;
      end
      chk("mid crd", 32'(m.crd), 1);
      chk("mid caddr_rd", 32'(m.caddr_rd), 500);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_mid busy", 32'(busy), 0);
      chk("rst_mid crd", 32'(m.crd), 0);
      chk("rst_mid csel", 32'(m.csel), 0);
      reset = 1'b0;
      for (int k = 0; k < N + 8; k++) begin
        @(negedge clk);
        if (m.cwr) ncwr++;
        if (done) ndone++;
      end
      chk("rst_mid no_cwr", ncwr, 0);
      chk("rst_mid no_done", ndone, 0);
      run_eval("after_rst", 20'h08000, -1);
    end

    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < N; i++) begin
        if (r == 4) begin
          feat[i] = 20'($urandom);
          wt[i]   = 20'($urandom);
        end else begin
          feat[i] = 20'($urandom_range(0, 8191)) - 20'd4096;
          wt[i]   = 20'($urandom_range(0, 8191)) - 20'd4096;
        end
      end
      run_eval($sformatf("rand%0d", r), model(), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fc_neuron.md
# fc_neuron

Single-neuron fully-connected stage placed directly downstream of the convolution/max-pool engine. After that engine has written the 32x32 pooled map to layer-1 memory (csel 3'b011), this block reads all 1024 Q4.16 features and multiplies each by a weight from a synchronous weight ROM. It accumulates the products at full precision, rounds and saturates the sum to Q4.16, and writes one result word to layer-2 memory (csel 3'b101).

## Interface
Parameters:
- N_IN, 1024, number of features and weights (power of two)
- DW, 20, data width, signed Q4.16
- FRAC, 16, fractional bits
- DST_ADDR, 12'd0, layer-2 write address

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin one evaluation; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until DONE
- done  out  1  one-cycle pulse when the result has been written
- crd  out  1  layer memory read strobe
- caddr_rd  out  12  read address, feature index 0..N_IN-1
- cdata_rd  in  20  signed read data, valid the cycle after crd/caddr_rd
- waddr  out  10  weight ROM address, equal to feature index
- wdata  in  20  signed weight, valid the cycle after waddr
- csel  out  3  3'b011 while reading, 3'b101 while writing, 3'b000 otherwise
- cwr  out  1  write strobe, single cycle
- caddr_wr  out  12  DST_ADDR during the write, else 0
- cdata_wr  out  20  rounded result, held from ROUND until the next start

## Operation
- States: IDLE -> FETCH -> LAST -> ROUND -> WRITE -> DONE -> IDLE.
- IDLE: all strobes low. start=1 moves to FETCH and clears the accumulator and index.
- FETCH: runs for exactly N_IN cycles. Cycle i drives crd=1, caddr_rd=i, waddr=i, csel=3'b011. From cycle 1 onward, the product of the previous cycle's cdata_rd and wdata is added. After i=N_IN-1, the state moves to LAST.
- LAST: crd=0. The final product is accumulated.
- ROUND: the result is computed as acc[DW+FRAC-1:FRAC] + acc[FRAC-1], which rounds half up. It saturates to 0x7FFFF or 0x80000 if the full accumulator lies outside the Q4.16 range. The result is registered into cdata_wr.
- WRITE: cwr=1, csel=3'b101, caddr_wr=DST_ADDR for one cycle.
- DONE: done=1 for one cycle, busy falls, and the state returns to IDLE.
- Arithmetic: each product is 2*DW = 40 bits signed. The accumulator is 2*DW+log2(N_IN) = 50 bits signed and never wraps.
- start while busy is ignored. start held high re-triggers on the IDLE cycle after DONE.
- reset at any time returns to IDLE on the next edge and clears the accumulator and index. All outputs go to 0; no partial write occurs.

## Timing
- Reset values: busy=0, done=0, crd=0, cwr=0, csel=0, caddr_rd=0, waddr=0, caddr_wr=0, cdata_wr=0.
- Edge E0 samples start. FETCH covers cycles E0+1 .. E0+N_IN.
- LAST is at E0+N_IN+1, ROUND at +N_IN+2, and WRITE (cwr high) at +N_IN+3.
- done is high at E0+N_IN+4, which is E0+1028 for the defaults.
- busy is high from E0+1 through the WRITE cycle.
- Throughput: one feature per cycle, with no bubbles inside FETCH.

## Configuration
- FC_RELU_EN defined: the saturated result passes through ReLU (negative becomes 0) before it is registered into cdata_wr.
- FC_RELU_EN undefined: the signed saturated result is written unchanged.
- Timing is identical in both builds.

## Structure
- Shared package cnn_pkg holds:
  - DW and FRAC;
  - csel constants CSEL_L0=3'b001, CSEL_L1=3'b011, CSEL_L2=3'b101;
  - the fc_state_t enum;
  - the Q4.16 max/min constants.
- One sub-module, fc_round_sat: a combinational 50-to-20-bit round-half-up plus saturate, with an optional ReLU under FC_RELU_EN. It is reusable by later dense stages.
- The FSM, index counter and MAC stay in fc_neuron.

## Test plan
- All features 0x10000, all weights 0x10000 -> sum is 1024.0, exceeds the range -> cdata_wr=0x7FFFF; cwr at E0+1027; done at E0+1028.
- Only feature 1023 = 0x10000 with weight 0x08000, others 0 -> cdata_wr=0x08000, which checks that the final LAST-cycle product is counted.
- Single feature 0x00001 with weight 0x08000 -> product 0x8000 rounds up -> cdata_wr=0x00001. Weight 0x07FFF -> 0x00000.
- Feature 0 = 0x10000, weight 0 = 0xF0000 (-1.0), rest 0 -> 0xF0000 without FC_RELU_EN, 0x00000 with it.
- reset asserted at FETCH cycle 500 -> next cycle busy=0, crd=0, and cwr never rises. A new start then completes normally with the correct result.
- start pulsed again at FETCH cycle 10 -> ignored; exactly one cwr and one done pulse.
